// File: rtl/prng_share_if.sv
// Request/grant and random-word bus between the shared PRNG controller and its consumers.
interface prng_share_if #(
  parameter int NREQ = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic            seed_load;
  logic [31:0]     seed;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            rnd_valid;
  logic [31:0]     rnd_data;
  logic [IDW-1:0]  rnd_id;
  logic            ready;

  modport master (
    output seed_load, seed, req,
    input  gnt, rnd_valid, rnd_data, rnd_id, ready
  );

  modport slave (
    input  seed_load, seed, req,
    output gnt, rnd_valid, rnd_data, rnd_id, ready
  );
endinterface

// File: rtl/prng_share_ctrl.sv
// Shared 32-bit LCG with xorshift/rotate output, seeded warm-up FSM and a
// round-robin arbiter delivering one tagged word per grant, one cycle later.
module prng_share_ctrl #(
  parameter int          NREQ    = 4,
  parameter logic [31:0] LCG_MUL = 32'd747796405,
  parameter logic [31:0] LCG_INC = 32'd2891336453,
  parameter int          WARMUP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  prng_share_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [8:0]      WARMUP_N = 9'(WARMUP);

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN} state_t;

  function automatic logic [31:0] lcg_step(input logic [31:0] s);
    return s * LCG_MUL + LCG_INC;
  endfunction

  // Rotating a doubled word avoids the 32-bit shift case when rot is zero.
  function automatic logic [31:0] perm(input logic [31:0] s);
    logic [31:0] xs;
    logic [63:0] dbl;
    xs  = s ^ (s >> 6);
    dbl = {xs, xs} >> s[31:27];
    return dbl[31:0];
  endfunction

  state_t          state, state_n;
  logic [7:0]      wcnt, wcnt_n;
  logic [IDW-1:0]  rr;
  logic [31:0]     lcg_state;
  logic            load, step, grant;
  logic            any_req;
  logic [IDW-1:0]  win;
  int              idx;

  logic [31:0]     cap_state_p0;
  logic [IDW-1:0]  cap_id_p0;
  logic            vld_p0;

  always_comb begin
    any_req = 1'b0;
    win     = '0;
    idx     = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(rr) + i) % NREQ;
      if (!any_req && bus.req[idx]) begin
        any_req = 1'b1;
        win     = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // A seed load takes precedence over everything and suppresses grants.
  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    load    = 1'b0;
    step    = 1'b0;
    grant   = 1'b0;
    if (bus.seed_load) begin
      load    = 1'b1;
      wcnt_n  = '0;
      state_n = (WARMUP == 0) ? S_RUN : S_WARMUP;
    end else begin
      case (state)
        S_IDLE: ;
        S_WARMUP: begin
          step   = 1'b1;
          wcnt_n = wcnt + 8'd1;
          if ({1'b0, wcnt} + 9'd1 >= WARMUP_N) state_n = S_RUN;
        end
        S_RUN: begin
          if (any_req) begin
            grant = 1'b1;
            step  = 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt          <= '0;
      rr            <= IDW'(NREQ - 1);
      lcg_state     <= '0;
      bus.gnt       <= '0;
      bus.ready     <= 1'b0;
      vld_p0        <= 1'b0;
      bus.rnd_valid <= 1'b0;
      bus.rnd_data  <= '0;
      bus.rnd_id    <= '0;
    end else begin
      wcnt      <= wcnt_n;
      bus.ready <= (state_n == S_RUN);
      if (load)      lcg_state <= bus.seed;
      else if (step) lcg_state <= lcg_step(lcg_state);
      if (grant) rr <= win;
      bus.gnt <= grant ? (ONE_HOT0 << win) : '0;
      vld_p0  <= grant;
      // p0 -> output: permute the captured state one cycle after its grant
      bus.rnd_valid <= vld_p0;
      if (vld_p0) begin
        bus.rnd_data <= perm(cap_state_p0);
        bus.rnd_id   <= cap_id_p0;
      end
    end
  end

  // grant -> p0: capture the pre-step LCG value and its owner
  always_ff @(posedge clk) begin
    if (grant) begin
      cap_state_p0 <= lcg_state;
      cap_id_p0    <= win;
    end
  end
endmodule

// File: tb/tb_prng_share_ctrl.sv
// Directed checks of the shared PRNG controller with WARMUP=0 and WARMUP=4 instances.
module tb_prng_share_ctrl;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  prng_share_if #(.NREQ(4)) if0 ();
  prng_share_if #(.NREQ(4)) if4 ();

  prng_share_ctrl #(.NREQ(4), .WARMUP(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  prng_share_ctrl #(.NREQ(4), .WARMUP(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] m_lcg(input logic [31:0] s);
    return s * 32'd747796405 + 32'd2891336453;
  endfunction

  function automatic logic [31:0] m_perm(input logic [31:0] s);
    logic [31:0] xs, o;
    int r;
    xs = s ^ {6'b0, s[31:6]};
    r  = int'(s[31:27]);
    for (int i = 0; i < 32; i++) o[i] = xs[(i + r) % 32];
    return o;
  endfunction

  logic [31:0] m4;
  logic [31:0] prev_word;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; if0.req = 4'b1111; if4.req = 4'b1111;
    tick(2);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (if0.gnt !== 4'b0 || if4.gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt got %b/%b exp 0000", if0.gnt, if4.gnt); end
      checks++; if (if0.rnd_valid !== 1'b0 || if4.rnd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b/%b exp 0", if0.rnd_valid, if4.rnd_valid); end
      checks++; if (if0.ready !== 1'b0 || if4.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b/%b exp 0", if0.ready, if4.ready); end
    end
    checks++; if (if0.rnd_data !== 32'h0 || if0.rnd_id !== 2'd0) begin errors++; $display("FAIL reset_data got %h/%0d exp 0/0", if0.rnd_data, if0.rnd_id); end
    if0.req = 4'b0; if4.req = 4'b0;
  endtask

  task automatic test_seq_w0();
    if0.seed = 32'h0; if0.seed_load = 1'b1;
    tick();
    if0.seed_load = 1'b0;
    checks++; if (if0.ready !== 1'b1 || if0.gnt !== 4'b0) begin errors++; $display("FAIL w0_ready got %b gnt %b exp 1 0000", if0.ready, if0.gnt); end
    if0.req = 4'b0001;
    tick();
    checks++; if (if0.gnt !== 4'b0001 || if0.rnd_valid !== 1'b0) begin errors++; $display("FAIL w0_gnt1 got %b v%b exp 0001 v0", if0.gnt, if0.rnd_valid); end
    tick();
    checks++; if (if0.gnt !== 4'b0001) begin errors++; $display("FAIL w0_gnt2 got %b exp 0001", if0.gnt); end
    checks++; if (if0.rnd_valid !== 1'b1 || if0.rnd_data !== 32'h00000000 || if0.rnd_id !== 2'd0) begin errors++; $display("FAIL w0_word1 got v%b %h id%0d exp v1 00000000 id0", if0.rnd_valid, if0.rnd_data, if0.rnd_id); end
    if0.req = 4'b0;
    tick();
    checks++; if (if0.gnt !== 4'b0) begin errors++; $display("FAIL w0_gnt3 got %b exp 0000", if0.gnt); end
    checks++; if (if0.rnd_valid !== 1'b1 || if0.rnd_data !== 32'h38914D77 || if0.rnd_id !== 2'd0) begin errors++; $display("FAIL w0_word2 got v%b %h id%0d exp v1 38914d77 id0", if0.rnd_valid, if0.rnd_data, if0.rnd_id); end
    tick();
    checks++; if (if0.rnd_valid !== 1'b0 || if0.rnd_data !== 32'h38914D77) begin errors++; $display("FAIL w0_hold got v%b %h exp v0 38914d77", if0.rnd_valid, if0.rnd_data); end
  endtask

  task automatic test_rot0();
    if0.seed = 32'h00000040; if0.seed_load = 1'b1; if0.req = 4'b0100;
    tick();
    if0.seed_load = 1'b0;
    checks++; if (if0.gnt !== 4'b0) begin errors++; $display("FAIL rot0_seedgnt got %b exp 0000", if0.gnt); end
    tick();
    checks++; if (if0.gnt !== 4'b0100) begin errors++; $display("FAIL rot0_gnt got %b exp 0100", if0.gnt); end
    if0.req = 4'b0;
    tick();
    checks++; if (if0.rnd_valid !== 1'b1 || if0.rnd_data !== 32'h00000041 || if0.rnd_id !== 2'd2) begin errors++; $display("FAIL rot0_word got v%b %h id%0d exp v1 00000041 id2", if0.rnd_valid, if0.rnd_data, if0.rnd_id); end
    tick();
  endtask

  task automatic test_warmup();
    logic [3:0] eg;
    if4.seed = 32'h12345678; if4.seed_load = 1'b1; if4.req = 4'b1111;
    m4 = 32'h12345678;
    tick();
    if4.seed_load = 1'b0;
    checks++; if (if4.ready !== 1'b0 || if4.gnt !== 4'b0) begin errors++; $display("FAIL wu_load got r%b %b exp r0 0000", if4.ready, if4.gnt); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      m4 = m_lcg(m4);
      checks++; if (if4.gnt !== 4'b0 || if4.ready !== (k == 4)) begin errors++; $display("FAIL wu_step%0d got r%b %b exp r%0d 0000", k, if4.ready, if4.gnt, (k == 4)); end
    end
    prev_word = 32'h0;
    for (int k = 0; k < 5; k++) begin
      tick();
      eg = 4'b0001 << (k % 4);
      checks++; if (if4.gnt !== eg) begin errors++; $display("FAIL wu_gnt%0d got %b exp %b", k, if4.gnt, eg); end
      if (k > 0) begin
        checks++; if (if4.rnd_valid !== 1'b1 || if4.rnd_id !== 2'((k - 1) % 4) || if4.rnd_data !== prev_word) begin errors++; $display("FAIL wu_word%0d got v%b %h id%0d exp v1 %h id%0d", k, if4.rnd_valid, if4.rnd_data, if4.rnd_id, prev_word, (k - 1) % 4); end
      end
      prev_word = m_perm(m4);
      m4 = m_lcg(m4);
    end
    if4.req = 4'b0;
    tick();
    checks++; if (if4.rnd_valid !== 1'b1 || if4.rnd_id !== 2'd0 || if4.rnd_data !== prev_word || if4.gnt !== 4'b0) begin errors++; $display("FAIL wu_last got v%b %h id%0d g%b exp v1 %h id0 g0000", if4.rnd_valid, if4.rnd_data, if4.rnd_id, if4.gnt, prev_word); end
    tick();
  endtask

  task automatic test_reseed();
    if4.req = 4'b0010;
    tick();
    checks++; if (if4.gnt !== 4'b0010) begin errors++; $display("FAIL rs_gnt got %b exp 0010", if4.gnt); end
    prev_word = m_perm(m4);
    if4.seed = 32'hCAFEF00D; if4.seed_load = 1'b1;
    tick();
    if4.seed_load = 1'b0;
    checks++; if (if4.gnt !== 4'b0 || if4.ready !== 1'b0) begin errors++; $display("FAIL rs_seedcyc got %b r%b exp 0000 r0", if4.gnt, if4.ready); end
    checks++; if (if4.rnd_valid !== 1'b1 || if4.rnd_id !== 2'd1 || if4.rnd_data !== prev_word) begin errors++; $display("FAIL rs_oldword got v%b %h id%0d exp v1 %h id1", if4.rnd_valid, if4.rnd_data, if4.rnd_id, prev_word); end
    m4 = 32'hCAFEF00D;
    for (int k = 1; k <= 4; k++) begin
      tick();
      m4 = m_lcg(m4);
      checks++; if (if4.gnt !== 4'b0 || if4.rnd_valid !== 1'b0 || if4.ready !== (k == 4)) begin errors++; $display("FAIL rs_wu%0d got g%b v%b r%b exp 0000 v0 r%0d", k, if4.gnt, if4.rnd_valid, if4.ready, (k == 4)); end
    end
    tick();
    checks++; if (if4.gnt !== 4'b0010) begin errors++; $display("FAIL rs_regnt got %b exp 0010", if4.gnt); end
    prev_word = m_perm(m4);
    if4.req = 4'b0;
    tick();
    checks++; if (if4.rnd_valid !== 1'b1 || if4.rnd_data !== prev_word || if4.rnd_id !== 2'd1) begin errors++; $display("FAIL rs_newword got v%b %h id%0d exp v1 %h id1", if4.rnd_valid, if4.rnd_data, if4.rnd_id, prev_word); end
    tick();
  endtask

  task automatic test_reset_mid();
    if0.req = 4'b0001;
    tick();
    checks++; if (if0.gnt !== 4'b0001) begin errors++; $display("FAIL rm_gnt got %b exp 0001", if0.gnt); end
    rst = 1'b1; if0.req = 4'b0;
    tick();
    rst = 1'b0;
    checks++; if (if0.rnd_valid !== 1'b0 || if0.gnt !== 4'b0 || if0.ready !== 1'b0) begin errors++; $display("FAIL rm_ctrl got v%b g%b r%b exp v0 g0000 r0", if0.rnd_valid, if0.gnt, if0.ready); end
    checks++; if (if0.rnd_data !== 32'h0 || if0.rnd_id !== 2'd0) begin errors++; $display("FAIL rm_data got %h id%0d exp 0 id0", if0.rnd_data, if0.rnd_id); end
    if0.req = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (if0.gnt !== 4'b0 || if0.ready !== 1'b0 || if0.rnd_valid !== 1'b0) begin errors++; $display("FAIL rm_idle%0d got g%b r%b v%b exp 0000 0 0", k, if0.gnt, if0.ready, if0.rnd_valid); end
    end
  endtask

  task automatic test_back_to_back();
    if0.seed = 32'h0; if0.seed_load = 1'b1;
    tick();
    if0.seed_load = 1'b0;
    tick();
    checks++; if (if0.gnt !== 4'b0001) begin errors++; $display("FAIL bb_gnt0 got %b exp 0001", if0.gnt); end
    tick();
    checks++; if (if0.gnt !== 4'b0010) begin errors++; $display("FAIL bb_gnt1 got %b exp 0010", if0.gnt); end
    checks++; if (if0.rnd_valid !== 1'b1 || if0.rnd_data !== 32'h0 || if0.rnd_id !== 2'd0) begin errors++; $display("FAIL bb_word0 got v%b %h id%0d exp v1 00000000 id0", if0.rnd_valid, if0.rnd_data, if0.rnd_id); end
    if0.req = 4'b0;
    tick();
    checks++; if (if0.rnd_valid !== 1'b1 || if0.rnd_data !== 32'h38914D77 || if0.rnd_id !== 2'd1) begin errors++; $display("FAIL bb_word1 got v%b %h id%0d exp v1 38914d77 id1", if0.rnd_valid, if0.rnd_data, if0.rnd_id); end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    if0.seed_load = 1'b0; if0.seed = '0; if0.req = '0;
    if4.seed_load = 1'b0; if4.seed = '0; if4.req = '0;
    m4 = '0; prev_word = '0;
    test_reset();
    test_seq_w0();
    test_rot0();
    test_warmup();
    test_reseed();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prng_share_ctrl.md
Name: prng_share_ctrl

Overview:
- Owns one 32-bit LCG state register and the xorshift/rotate output permutation, and shares the generator between NREQ requesters.
- A round-robin arbiter issues at most one grant per cycle. The granted requester receives one permuted word, tagged with its index, one cycle after the grant.
- A seed-load / warm-up state machine keeps requesters out until the generator is seeded and stepped WARMUP times.
- Sits between the PRNG datapath and its consumers.

Parameters:
- NREQ, 4, number of requesters (2..16)
- LCG_MUL, 32'd747796405, LCG multiplier
- LCG_INC, 32'd2891336453, LCG increment (odd)
- WARMUP, 4, LCG steps discarded after every seed load (0..255)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- seed_load  in  1  single-cycle pulse: load seed and restart warm-up
- seed  in  32  seed value, sampled when seed_load=1
- req  in  NREQ  level request per requester
- gnt  out  NREQ  one-hot grant pulse, registered
- rnd_valid  out  1  rnd_data/rnd_id valid, one-cycle pulse
- rnd_data  out  32  permuted random word
- rnd_id  out  $clog2(NREQ)  index of the requester owning rnd_data
- ready  out  1  high in RUN state only

Behaviour:
- All outputs and state are registered and update on posedge clk.
- Reset (rst=1):
  - FSM=IDLE, lcg_state=0, rr pointer=NREQ-1 (so index 0 has priority first).
  - gnt=0, rnd_valid=0, rnd_data=0, rnd_id=0, ready=0.
  - Reset mid-operation discards any in-flight word: no rnd_valid is issued the cycle after.
- LCG step: lcg_state <= lcg_state*LCG_MUL + LCG_INC, truncated mod 2^32.
- Permutation perm(s):
  - xs = s ^ (s >> 6); rot = s[31:27]; result = xs rotated right by rot.
  - rot=0 must yield xs unchanged; no 32-bit shift artefacts are allowed.
- FSM:
  - IDLE: no grants, no LCG steps. seed_load -> WARMUP, with lcg_state<=seed and wcnt<=0.
  - WARMUP: one LCG step per cycle, wcnt++. When wcnt reaches WARMUP -> RUN. With WARMUP=0, the FSM enters RUN the cycle after seed_load with lcg_state=seed unstepped.
  - RUN: ready=1 and arbitration is active.
  - seed_load in any state (including WARMUP and RUN) reloads lcg_state, clears wcnt and enters WARMUP (or RUN if WARMUP=0). A seed_load cycle never issues a grant, even if req!=0.
- Arbitration (RUN only, evaluated on current-cycle req):
  - Search starts at index (rr+1) mod NREQ and wraps; the first set bit wins.
  - In the winning cycle: gnt<=onehot(win), rr<=win, capture stage<=(lcg_state, win), and lcg_state steps.
  - No requests: gnt=0, LCG holds, rr holds.
- Output stage:
  - The cycle after a grant: rnd_valid=1, rnd_data=perm(captured lcg_state), rnd_id=win.
  - Latency from gnt to rnd_valid is exactly 1 cycle. Throughput is 1 word/cycle.
  - A lone requester holding req is granted every cycle.
- Words are consumed in grant order. Each LCG value is delivered at most once and none is skipped in RUN.
- A seed_load arriving the cycle after a grant does not cancel the in-flight word: rnd_valid still pulses with the pre-seed value.
- rnd_data and rnd_id hold their last values while rnd_valid=0.
- req must be held until gnt is seen. Holding req after gnt requests another word.

Test Plan:
- Reset, then idle: with rst=1 for 2 cycles and req=4'b1111, stay idle for 5 cycles -> gnt=0, rnd_valid=0, ready=0 throughout.
- Sequence with WARMUP=0: seed_load with seed=0, then req=4'b0001 held 2 grants -> rnd_data 0x00000000 then 0x38914D77, rnd_id=0, each 1 cycle after its gnt.
- rot=0 case with WARMUP=0: seed=0x00000040, one grant to requester 2 -> rnd_data=0x00000041, rnd_id=2.
- Warm-up with WARMUP=4: seed_load, req=4'b1111 held -> no gnt for 4 cycles; ready rises on cycle 5; grants then rotate 0,1,2,3,0 on consecutive cycles.
- Mid-stream reseed: in RUN, grant to requester 1, then seed_load the next cycle with req=4'b0010 -> rnd_valid pulses once with the old word, no gnt during the seed cycle, then warm-up restarts.
- Mid-stream reset: assert rst the cycle after a grant -> rnd_valid stays 0, all outputs return to reset values, and the FSM stays in IDLE until seed_load.
